// File: rtl/c17_key_load_ctrl.sv
// c17_key_load_ctrl: serial key loader for the key-locked c17 netlist.
// A key is shifted in MSB first and checked against an allowed-key mask.
// A passing key is committed to the key register that drives the D_x
// key-mux selects. key_valid is raised only after a settle window.
// Consecutive rejections are counted, and reaching MAX_FAIL of them locks
// the block until reset.
module c17_key_load_ctrl #(
    parameter int                       KEY_W      = 2,
    parameter logic [(1 << KEY_W) - 1:0] ALLOW_VEC = 4'b1001,
    parameter int                       SETTLE_CYC = 2,
    parameter int                       MAX_FAIL   = 3,
    parameter logic [KEY_W-1:0]         LOCK_KEY   = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic             key_sdi,
    input  logic             key_sdi_vld,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             busy,
    output logic             done,
    output logic             key_err,
    output logic             locked
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SHIFT  = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_LOCKED = 3'd4;

    localparam int             CNT_W       = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(KEY_W - 1);
    localparam logic [3:0]     SETTLE_LAST = (SETTLE_CYC > 0) ? 4'(SETTLE_CYC - 1) : 4'd0;
    localparam logic [3:0]     FAIL_MAX    = 4'(MAX_FAIL);

    logic [1:0]       rst_sync_q;
    logic             rst_int_n;

    logic [2:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [KEY_W-1:0] sh_q,     sh_d;
    logic [KEY_W-1:0] key_q,    key_d;
    logic             valid_q,  valid_d;
    logic             done_q,   done_d;
    logic             err_q,    err_d;
    logic [3:0]       fail_q,   fail_d;
    logic [3:0]       settle_q, settle_d;
    logic [3:0]       fail_inc;

    // Reset synchronizer: the reset asserts asynchronously and releases on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    // Next-state and output logic for the load / check / settle sequence.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        key_d    = key_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        fail_d   = fail_q;
        settle_d = settle_q;
        fail_inc = (fail_q == FAIL_MAX) ? fail_q : fail_q + 4'd1;

        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    sh_d    = '0;
                    valid_d = 1'b0;
                end
            end

            ST_SHIFT: begin
                // A restart takes priority, and any bit offered with it is dropped.
                if (load_start) begin
                    cnt_d = '0;
                    sh_d  = '0;
                end else if (key_sdi_vld) begin
                    sh_d  = KEY_W'({sh_q, key_sdi});
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_d = ST_CHECK;
                    end
                end
            end

            ST_CHECK: begin
                if (ALLOW_VEC[sh_q]) begin
                    key_d  = sh_q;
                    fail_d = 4'd0;
                    if (SETTLE_CYC == 0) begin
                        valid_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        settle_d = 4'd0;
                        state_d  = ST_SETTLE;
                    end
                end else begin
                    err_d  = 1'b1;
                    fail_d = fail_inc;
                    if (fail_inc == FAIL_MAX) begin
                        state_d = ST_LOCKED;
                        key_d   = LOCK_KEY;
                        valid_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_SETTLE: begin
                // An abort keeps the newly committed key but never reports it valid.
                if (load_start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    sh_d    = '0;
                end else if (settle_q == SETTLE_LAST) begin
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end

            ST_LOCKED: begin
                key_d   = LOCK_KEY;
                valid_d = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_int_n) begin
        // NOTE: every register is reset here, because the outputs must drop to known values as soon as reset asserts.
        if (!rst_int_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sh_q     <= '0;
            key_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            fail_q   <= 4'd0;
            settle_q <= 4'd0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the values from before the edge.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            key_q    <= key_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            err_q    <= err_d;
            fail_q   <= fail_d;
            settle_q <= settle_d;
        end
    end

    assign key_out   = key_q;
    assign key_valid = valid_q;
    assign done      = done_q;
    assign key_err   = err_q;
    assign busy      = (state_q == ST_SHIFT) || (state_q == ST_CHECK) || (state_q == ST_SETTLE);
    assign locked    = (state_q == ST_LOCKED);

endmodule

// File: doc/c17_key_load_ctrl.md
Name: c17_key_load_ctrl

Overview:
- Sequential controller that configures the key inputs (D_0, D_1) of the key-locked c17 netlist.
- Loads a key serially and checks it against a parameterised allowed-key set (default: allowed keys 00 and 11).
- Commits a passing key to a held key register that drives the netlist's key-mux selects. key_valid asserts only after a settle window, when the combinational datapath is stable.
- Counts failed loads and locks out permanently after MAX_FAIL consecutive rejections.

Parameters:
- KEY_W, 2: key width in bits; legal range 1..8; key_out[KEY_W-1] maps to D_(KEY_W-1).
- ALLOW_VEC, 4'b1001: 2**KEY_W-bit allow mask; bit k=1 means key value k is permitted. Default permits 00 and 11.
- SETTLE_CYC, 2: cycles from key_out update to key_valid; range 0..15.
- MAX_FAIL, 3: consecutive rejected loads that force LOCKED; range 1..15.
- LOCK_KEY, 0: value forced onto key_out in LOCKED.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- load_start, input, 1: pulse; begins (or restarts) a key load.
- key_sdi, input, 1: serial key bit, MSB first.
- key_sdi_vld, input, 1: key_sdi is valid this cycle.
- key_out, output, KEY_W: registered key to the netlist D inputs.
- key_valid, output, 1: key_out is committed and settled.
- busy, output, 1: high in SHIFT, CHECK and SETTLE.
- done, output, 1: one-cycle pulse when key_valid rises.
- key_err, output, 1: one-cycle pulse on rejected key.
- locked, output, 1: lockout active.

Behaviour:
- Reset (async assert, sync deassert inside block): state=IDLE; key_out=0, key_valid=0, busy=0, done=0, key_err=0, locked=0; fail count=0; shift register=0.
- States: IDLE, SHIFT, CHECK, SETTLE, LOCKED.
- IDLE:
  - load_start -> SHIFT; clear bit count and shift register.
  - key_valid clears on that same edge; key_out holds its previous value.
- SHIFT:
  - Each cycle with key_sdi_vld=1: sh <= {sh[KEY_W-2:0], key_sdi}; count++.
  - On the edge accepting bit KEY_W-1 -> CHECK.
  - key_sdi_vld=0 stalls with no timeout.
  - load_start in SHIFT restarts: count=0, sh=0, stay in SHIFT. load_start has priority over a simultaneous key_sdi_vld; that bit is dropped.
- CHECK (exactly 1 cycle):
  - If ALLOW_VEC[sh]=1: key_out <= sh and fail count <= 0. Then SETTLE if SETTLE_CYC>0; otherwise key_valid=1 and done=1 on the same edge, then IDLE.
  - If ALLOW_VEC[sh]=0: key_err pulses for one cycle, fail count++, key_out unchanged, key_valid stays 0. If the new count == MAX_FAIL -> LOCKED, else -> IDLE.
  - load_start is ignored in CHECK.
- SETTLE:
  - Counts SETTLE_CYC cycles after the key_out update.
  - On the edge ending the count: key_valid=1, done=1 for one cycle, -> IDLE.
  - load_start in SETTLE aborts: key_valid stays 0, key_out keeps the new key, -> SHIFT with cleared count.
- LOCKED:
  - key_out=LOCK_KEY, key_valid=0, locked=1, busy=0.
  - All inputs ignored; only rst_n exits.
- busy=1 exactly in SHIFT, CHECK and SETTLE.
- done and key_err are never high in the same cycle.
- Reset asserted mid-operation returns every output to its reset value immediately, without waiting for a clock edge.
- Fail count saturates at MAX_FAIL. A successful commit resets it to 0, so rejections must be consecutive to reach lockout.

Test Plan:
- Good load (defaults): reset, load_start, sdi 1,1 on consecutive cycles. Required: CHECK at the next edge; key_out=2'b11 at the following edge E; key_valid=1 and done pulse at E+2; busy low from E+2.
- Rejected key: after committing 11, load_start, sdi 0,1. Required: key_valid drops at the start edge; key_err pulses once; key_out stays 11; locked=0; done never asserts.
- Lockout: three consecutive loads of key 01 or 10. Required: third key_err accompanied by locked=1 and key_out=00. A subsequent load_start plus bits 1,1 produces no change. rst_n low clears locked.
- Restart and stall: load_start, bit 1, load_start, then bits 0,0 with a 3-cycle key_sdi_vld gap between them. Required: key_out=00, key_valid after 2 settle cycles, no key_err.
- Settle abort and reset: load 11, assert load_start one cycle into SETTLE. Required: no done; SHIFT entered. Separately, pulse rst_n low mid-SETTLE. Required: key_out=0 and all flags 0 asynchronously.
- Parameter sweep: SETTLE_CYC=0 -> key_valid and done on the same edge as key_out. KEY_W=3 with ALLOW_VEC=8'h81 -> 111 accepted, 101 rejected.
